// File: rtl/offchip_lane_rx_if.sv
// Link-side and consumer-side signals of the off-chip lane receiver.
// The master drives beats, ready and err_clr; the slave (receiver) returns words, credits and error flags.
interface offchip_lane_rx_if;
    logic [15:0] lane_data;
    logic        lane_valid;
    logic        lane_sof;
    logic [63:0] data_out;
    logic        valid_out;
    logic        ready;
    logic        credit_ret;
    logic        err_clr;
    logic        err_proto;
    logic        err_ovf;

    modport master (
        output lane_data, lane_valid, lane_sof, ready, err_clr,
        input  data_out, valid_out, credit_ret, err_proto, err_ovf
    );

    modport slave (
        input  lane_data, lane_valid, lane_sof, ready, err_clr,
        output data_out, valid_out, credit_ret, err_proto, err_ovf
    );
endinterface

// File: rtl/offchip_lane_rx.sv
// Assembles four interleaved 16-bit link beats into 64-bit words and queues them in a
// first-word-fall-through FIFO, returning one credit per popped entry.
module offchip_lane_rx #(
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    offchip_lane_rx_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    typedef enum logic [1:0] {EXP0, EXP1, EXP2, EXP3} state_e;

    state_e        state_q, state_d;
    logic [23:0]   hi_q, hi_d, lo_q, lo_d;
    logic [63:0]   mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          credit_q;
    logic          perr_q, perr_d, oerr_q, oerr_d;
    logic          push, pop, full, push_ok, proto_viol;
    logic [63:0]   word;
    logic [4:0]    bofs;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Beats 0..2 are held split into high/low byte lanes; beat 3 is merged straight from the link.
    assign bofs = {state_q, 3'b000};
    assign word = {bus.lane_data[15:8], hi_q, bus.lane_data[7:0], lo_q};

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        push       = 1'b0;
        proto_viol = 1'b0;
        if (bus.lane_valid) begin
            if (bus.lane_sof) begin
                // sof mid-word resyncs: the partial word is abandoned and this beat restarts it.
                proto_viol = (state_q != EXP0);
                hi_d[7:0]  = bus.lane_data[15:8];
                lo_d[7:0]  = bus.lane_data[7:0];
                state_d    = EXP1;
            end else begin
                case (state_q)
                    EXP0: proto_viol = 1'b1;
                    EXP3: begin
                        push    = 1'b1;
                        state_d = EXP0;
                    end
                    default: begin
                        hi_d[bofs +: 8] = bus.lane_data[15:8];
                        lo_d[bofs +: 8] = bus.lane_data[7:0];
                        state_d = (state_q == EXP1) ? EXP2 : EXP3;
                    end
                endcase
            end
        end
    end

    assign pop     = bus.valid_out && bus.ready;
    assign full    = (cnt_q == FULL_CNT);
    assign push_ok = push && (!full || pop);

    always_comb begin
        wptr_d = push_ok ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop ? ptr_inc(rptr_q) : rptr_q;
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        // A new error beats err_clr in the same cycle.
        perr_d = proto_viol ? 1'b1 : (bus.err_clr ? 1'b0 : perr_q);
        oerr_d = (push && !push_ok) ? 1'b1 : (bus.err_clr ? 1'b0 : oerr_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= EXP0;
            hi_q     <= '0;
            lo_q     <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            credit_q <= 1'b0;
            perr_q   <= 1'b0;
            oerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            credit_q <= pop;
            perr_q   <= perr_d;
            oerr_q   <= oerr_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wptr_q] <= word;
        end
    end

    assign bus.data_out   = mem_q[rptr_q];
    assign bus.valid_out  = (cnt_q != '0);
    assign bus.credit_ret = credit_q;
    assign bus.err_proto  = perr_q;
    assign bus.err_ovf    = oerr_q;
endmodule

// File: doc/offchip_lane_rx.md
OFFCHIP_LANE_RX -- requirements
Module: offchip_lane_rx

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of 64-bit FIFO entries, which is also the number of credits the transmitter owns after reset.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port lane_data, input, 16 bits: one link beat.
REQ-006 SHALL have port lane_valid, input, 1 bit: the beat is present this cycle; there is no backpressure.
REQ-007 SHALL have port lane_sof, input, 1 bit: qualified by lane_valid; marks beat 0 of a word.
REQ-008 SHALL have port data_out, output, 64 bits: FIFO head word.
REQ-009 SHALL have port valid_out, output, 1 bit: data_out is valid.
REQ-010 SHALL have port ready, input, 1 bit: the consumer accepts data_out.
REQ-011 SHALL have port credit_ret, output, 1 bit: one-cycle pulse returning one credit per popped entry.
REQ-012 SHALL have port err_clr, input, 1 bit: synchronous clear of both sticky error flags.
REQ-013 SHALL have port err_proto, output, 1 bit: sticky flag for a framing violation.
REQ-014 SHALL have port err_ovf, output, 1 bit: sticky flag for a push while the FIFO is full.

Function
REQ-015 SHALL de-interleave beat k (k = 0..3) as word[39+8k:32+8k] = lane_data[15:8] and word[7+8k:8k] = lane_data[7:0].
REQ-016 SHALL run a 2-bit assembly FSM with states EXP0, EXP1, EXP2, EXP3; a beat is accepted only when lane_valid=1.
REQ-017 SHALL, in EXP0 with lane_sof=1, store the beat as beat 0 and go to EXP1.
REQ-018 SHALL, in EXP0 with lane_sof=0, drop the beat, set err_proto, and stay in EXP0.
REQ-019 SHALL, in EXP1 or EXP2 with lane_sof=0, store beat 1 or beat 2 and advance to the next state.
REQ-020 SHALL, in EXP3 with lane_sof=0, store beat 3, push the assembled word into the FIFO on the same edge, and go to EXP0.
REQ-021 SHALL, in EXP1..EXP3 with lane_sof=1, discard the partial word, set err_proto, store this beat as beat 0, and go to EXP1 (resync).
REQ-022 SHALL hold the FSM state when lane_valid=0; gaps between beats of any length are legal.
REQ-023 SHALL implement the FIFO as first-word-fall-through with DEPTH entries and an occupancy count of 0..DEPTH; wptr and rptr wrap modulo DEPTH.
REQ-024 SHALL drive valid_out = (count != 0) and data_out = entry[rptr], both combinationally from registers.
REQ-025 SHALL pop when valid_out && ready.
REQ-026 SHALL make the first valid_out appear the cycle after the edge that accepts beat 3, giving 1-cycle latency from beat 3 to valid_out.
REQ-027 SHALL, on a push with count == DEPTH and no pop in the same cycle, drop the word, set err_ovf, and leave count and pointers unchanged.
REQ-028 SHALL accept both operations on a simultaneous push and pop, including when full, leaving count unchanged.
REQ-029 SHALL make a pop when empty impossible, since valid_out=0 when empty.
REQ-030 SHALL register credit_ret high for exactly one cycle after each pop edge, one pulse per pop, with back-to-back pops giving consecutive pulses.
REQ-031 SHALL give setting a sticky error priority over err_clr in the same cycle.
REQ-032 SHALL keep stored FIFO entries unaffected by protocol errors.

Reset
REQ-033 SHALL, while rst=0, asynchronously force FSM=EXP0, wptr=rptr=count=0, credit_ret=0, err_proto=0, err_ovf=0, and the assembly register to 0.
REQ-034 SHALL hold outputs at reset values while rst=0: valid_out=0, data_out=0 (the entry at rptr is reset to 0), credit_ret=0, err_proto=0, err_ovf=0.
REQ-035 SHALL lose any partial word on reset mid-assembly and start the first beat after reset release in EXP0.
REQ-036 SHALL deassert reset synchronously to clk, which is the integration's responsibility; the block samples no input while rst=0.

Verification
REQ-037 SHALL cover basic assembly: beats 0x5511(sof), 0x6622, 0x7733, 0x8844 on consecutive cycles with ready=1 -> data_out=0x8877665544332211 and valid_out=1 for one cycle starting 1 cycle after beat 3, then credit_ret pulses once on the following cycle.
REQ-038 SHALL cover gapped beats and backpressure: the same word with 2 idle cycles between beats and ready=0 -> valid_out holds, data_out is stable, and credit_ret=0 until ready=1, then one credit_ret pulse.
REQ-039 SHALL cover fill and overflow: 5 words pushed with ready=0 and DEPTH=4 -> count=4, err_ovf=1, the 5th word is absent, and draining returns words 1-4 in order with 4 credit_ret pulses.
REQ-040 SHALL cover framing errors: sof on beat 2, followed by a full word 0xA1B2C3D4E5F60718 -> err_proto=1, only 0xA1B2C3D4E5F60718 is output, and err_clr then clears err_proto.
REQ-041 SHALL cover simultaneous push and pop when full: FIFO full, ready=1 held, beat 3 of a new word arrives -> count stays 4, err_ovf=0, and the new word is output last.
REQ-042 SHALL cover reset mid-word: rst=0 after beat 1 -> outputs return to reset values immediately, and a subsequent complete word assembles correctly.
